// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side issues operands and consumes results.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrow,
        input  ovf,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrow,
        output ovf,
        output zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock.
// Result and borrow/ovf/zero flags held until the consumer accepts.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             ai, bi, di, br_nxt;
    logic [WIDTH-1:0] res;

    always_comb begin
        ai     = a_q[0];
        bi     = b_q[0];
        di     = ai ^ bi ^ br_q;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);
        res    = {di, sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sh_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = res;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // ai/bi are the operand MSBs on this last bit
                    diff_d   = res;
                    borrow_d = br_nxt;
                    ovf_d    = (ai != bi) && (di != ai);
                    zero_d   = ~|res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so it stays low through reset and rises one edge later
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sh_q       <= '0;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sh_q       <= sh_d;
            br_q       <= br_d;
            cnt_q      <= cnt_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an
// arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hs;
    int   done_ops;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) hs++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int a, input int b, output logic [W-1:0] d,
                         output logic br, output logic ov, output logic z);
        int r, sa, sb, sr;
        r  = a - b;
        if (r < 0) r += 2 ** W;
        sa = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
        sb = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
        sr = sa - sb;
        d  = r[W-1:0];
        br = (a < b);
        ov = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
        z  = (r == 0);
    endtask

    task automatic do_op(input int a, input int b, input int hold,
                         input bit bp);
        logic [W-1:0] ed;
        logic eb, eo, ez;
        int t;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            step();
            t++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 1);
        if (!bus.in_ready) return;
        model(a, b, ed, eb, eo, ez);
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.in_valid = 1'b1;
        step();
        check("in_ready_busy", 32'(bus.in_ready), 0);
        for (int k = 0; k < W; k++) begin
            check("latency", 32'(bus.out_valid), 0);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("out_valid", 32'(bus.out_valid), 1);
        check("diff", 32'(bus.diff), 32'(ed));
        check("borrow", 32'(bus.borrow), 32'(eb));
        check("ovf", 32'(bus.ovf), 32'(eo));
        check("zero", 32'(bus.zero), 32'(ez));
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = bp ? 1'b1 : 1'($urandom_range(0, 1));
            bus.a         = 1;
            bus.b         = 1;
            step();
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_diff", 32'(bus.diff), 32'(ed));
            check("hold_flags", {bus.borrow, bus.ovf, bus.zero},
                  {eb, eo, ez});
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        step();
        bus.out_ready = 1'b0;
        done_ops++;
        check("drain_valid", 32'(bus.out_valid), 0);
        check("drain_in_ready", 32'(bus.in_ready), 1);
        check("drain_diff_kept", 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        int t;
        checks        = 0;
        errors        = 0;
        done_ops      = 0;
        hs            = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_diff", 32'(bus.diff), 0);
        check("rst_flags", {bus.borrow, bus.ovf, bus.zero}, 0);
        #18 rst_n = 1'b1;
        step();
        check("in_ready_after_rst", 32'(bus.in_ready), 1);

        do_op(7, 3, 0, 0);
        do_op(3, 7, 0, 0);
        do_op(5, 5, 0, 0);
        do_op(8, 1, 0, 0);
        do_op(7, 15, 0, 0);
        do_op(6, 2, 10, 1);

        // Abort an operation two cycles after accept
        t = 0;
        while (!bus.in_ready && t < 50) begin
            step();
            t++;
        end
        bus.a        = 9;
        bus.b        = 2;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 0);
        check("abort_diff", 32'(bus.diff), 0);
        check("abort_flags", {bus.borrow, bus.ovf, bus.zero}, 0);
        check("abort_in_ready", 32'(bus.in_ready), 0);
        #10 rst_n = 1'b1;
        step();
        do_op(2, 1, 0, 0);

        for (int n = 0; n < 200; n++) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            do_op(int'($urandom_range(0, 2 ** W - 1)),
                  int'($urandom_range(0, 2 ** W - 1)),
                  int'($urandom_range(0, 3)), 0);
        end
        step();
        check("handshakes", 32'(hs), 32'(done_ops));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
